mult_pipe_sat: RTL and testbench
================================

// Module: mult_pipe_sat
// PURPOSE
//  Parametrised, pipelined signed multiplier with valid/ready handshake, fixed-point rescale and
//  output saturation. It is the drop-in successor to the 16x16 combinational multiplier used by the
//  FIR and echo datapaths: coefficient x sample -> Q-format result at OUT_W bits, with backpressure
//  so it can sit between the sample FIFO and the accumulator without external stall logic.
// PARAMETERS
//  A_W     16  width of signed operand dataa (2..32)
//  B_W     16  width of signed operand datab (2..32)
//  OUT_W   16  width of signed saturated result (2..A_W+B_W)
//  SHIFT   15  arithmetic right shift applied to full product (0..A_W+B_W-2); 15 = Q15 x Q15 -> Q15
//  STAGES  3   pipeline depth in register stages, >=2 (stage 1 = operand regs, last = output regs)
// PORTS
//  clock      in   1       rising-edge clock, single domain
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       dataa/datab valid this cycle
//  in_ready   out  1       block accepts operands this cycle
//  dataa      in   A_W     signed operand A
//  datab      in   B_W     signed operand B
//  out_valid  out  1       result/overflow valid
//  out_ready  in   1       downstream accepts result this cycle
//  result     out  OUT_W   signed rescaled, saturated product
//  overflow   out  1       result was clipped to +max/-min (qualified by out_valid)
// BEHAVIOUR
//  - Reset (sync, active-high): all stage valid bits = 0, result = 0, overflow = 0, out_valid = 0;
//    in_ready = 0 while reset is high, and in_ready = 1 on the first cycle after reset is released.
//  - Global advance: adv = ~out_valid | out_ready. in_ready = adv & ~reset (combinational).
//  - Accept: an operand pair is captured only when in_valid & in_ready. When adv = 1, every stage shifts
//    one place and the valid bits shift with it; stage-1 valid <= in_valid. When adv = 0, all stages hold.
//  - Latency: exactly STAGES cycles from accept to out_valid when out_ready is held high.
//    Throughput is 1 result/clock. No bubble collapsing: an internal bubble still occupies its stage.
//  - Output held stable (result, overflow, out_valid) while out_valid & ~out_ready.
//  - Arithmetic: P = $signed(dataa) * $signed(datab), full A_W+B_W bits, no intermediate truncation.
//    S = P >>> SHIFT, computed at A_W+B_W+1 bits (rounding mode below).
//    If S > 2^(OUT_W-1)-1: result = 2^(OUT_W-1)-1, overflow = 1.
//    If S < -2^(OUT_W-1): result = -2^(OUT_W-1), overflow = 1. Otherwise result = S[OUT_W-1:0], overflow = 0.
//  - Multiply is registered after stage 1 and rescale/saturation sits in the last stage; extra stages
//    (STAGES > 2) are retiming registers on P, for mapping to DSP blocks.
//  - Corner: (-2^(A_W-1)) * (-2^(B_W-1)) must saturate; at defaults, -32768 * -32768 -> 32767, overflow = 1.
//  - Simultaneous accept and emit in the same cycle is legal and loses no data.
//  - Reset mid-operation: all in-flight data is discarded; no out_valid pulse follows reset.
//  - Elaboration: $error if STAGES < 2, OUT_W > A_W+B_W, or SHIFT > A_W+B_W-2.
// CONFIGURATION
//  MULT_ROUND_EN defined: round half up before the shift, S = (P + 2^(SHIFT-1)) >>> SHIFT
//    (no-op when SHIFT = 0); the addition is done at A_W+B_W+1 bits so it cannot wrap.
//  MULT_ROUND_EN undefined: truncation toward -inf, S = P >>> SHIFT. Latency and ports are identical.
// TESTING (defaults unless stated)
//  1 Reset release: after reset -> out_valid = 0, result = 0, in_ready = 1; no spurious out_valid within 10 cycles.
//  2 Q15: 16384 * 16384 (0.5 x 0.5), out_ready = 1 -> result = 8192, overflow = 0, exactly 3 cycles after accept.
//  3 Saturation: -32768 * -32768 -> 32767, overflow = 1; 32767 * -32768 -> -32767, overflow = 0.
//  4 Rounding: 3 * 16384 (P = 49152) -> 2 with MULT_ROUND_EN, 1 without; -3 * 16384 -> -1 / -2.
//  5 Backpressure: stream 8 random pairs while toggling out_ready 1010... -> all 8 results match the
//    golden model, in order, with none dropped or duplicated; result is stable while stalled.
//  6 Reset mid-stream: assert reset with 3 pairs in flight -> zero results emerge; the next accepted pair
//    emerges STAGES cycles later. Sweep A_W=B_W=12, OUT_W=24, SHIFT=0, STAGES=4 and compare with the exact product.

Source files
------------

// File: rtl/mult_pipe_sat.sv
// mult_pipe_sat: pipelined signed multiplier with a valid/ready handshake,
// an arithmetic right-shift rescale and saturation to OUT_W bits.
// Stage 1 registers the operands. The middle stages (STAGES-2 of them) are
// retiming registers on the full product. The last stage registers the
// rescaled, saturated result.
// Optional feature: define MULT_ROUND_EN to round half up before the shift.
// Without it, the shift truncates toward -inf.
module mult_pipe_sat #(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int STAGES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   dataa,
  input  logic [B_W-1:0]   datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow
);

  localparam int W = A_W + B_W;

  // Saturation bounds, built at W+1 bits so that OUT_W up to W never overflows an int.
  localparam logic signed [W:0] MAXV = {{(W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [W:0] MINV = ~MAXV;

  if (STAGES < 2) begin : g_chk_stages
    $error("mult_pipe_sat: STAGES must be >= 2");
  end
  if (OUT_W > W) begin : g_chk_out_w
    $error("mult_pipe_sat: OUT_W must not exceed A_W+B_W");
  end
  if (SHIFT > W - 2) begin : g_chk_shift
    $error("mult_pipe_sat: SHIFT must not exceed A_W+B_W-2");
  end

  logic                  adv;
  logic [STAGES-2:0]     vld;
  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic signed [W-1:0]   prod;
  logic signed [W-1:0]   p_last;
  logic signed [W:0]     s_ext;
  logic signed [W:0]     s_shr;
  logic [OUT_W-1:0]      sat_res;
  logic                  sat_ovf;

  // The whole pipeline moves together. It stalls only while a result waits at the output.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~reset;

  // Valid bits for stages 1..STAGES-1. Bubbles occupy their stage.
  if (STAGES > 2) begin : g_vld_shift
    // Shift the valid chain on every advance.
    always_ff @(posedge clock) begin
      if (reset) begin
        vld <= '0;
      end else if (adv) begin
        vld <= {vld[STAGES-3:0], in_valid};
      end
    end
  end else begin : g_vld_single
    // Single valid bit for the operand stage.
    always_ff @(posedge clock) begin
      if (reset) begin
        vld <= '0;
      end else if (adv) begin
        vld <= in_valid;
      end
    end
  end

  // Operand stage: capture a pair only on a real accept.
  always_ff @(posedge clock) begin
    if (adv && in_valid && !reset) begin
      a_q <= dataa;
      b_q <= datab;
    end
  end

  // Full-width signed product. Size casts sign-extend the signed operands.
  assign prod = W'(a_q) * W'(b_q);

  if (STAGES > 2) begin : g_retime
    for (genvar g = 0; g < STAGES - 2; g++) begin : g_st
      logic signed [W-1:0] q;
      if (g == 0) begin : g_first
        // First retiming register takes the raw product.
        always_ff @(posedge clock) begin
          if (adv) begin
            q <= prod;
          end
        end
      end else begin : g_next
        // Later retiming registers pass the product along.
        always_ff @(posedge clock) begin
          if (adv) begin
            q <= g_st[g-1].q;
          end
        end
      end
    end
    assign p_last = g_st[STAGES-3].q;
  end else begin : g_direct
    assign p_last = prod;
  end

  // Rescale at W+1 bits (optionally rounded), then clip to the OUT_W signed range.
  always_comb begin
    s_ext = {p_last[W-1], p_last};
`ifdef MULT_ROUND_EN
    if (SHIFT > 0) begin
      s_ext = s_ext + ((W + 1)'(1) << (SHIFT - 1));
    end
`endif
    s_shr   = s_ext >>> SHIFT;
    sat_res = s_shr[OUT_W-1:0];
    sat_ovf = 1'b0;
    if (s_shr > MAXV) begin
      sat_res = MAXV[OUT_W-1:0];
      sat_ovf = 1'b1;
    end else if (s_shr < MINV) begin
      sat_res = MINV[OUT_W-1:0];
      sat_ovf = 1'b1;
    end
  end

  // Output stage: hold while stalled, otherwise load the next stage (bubbles included).
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (adv) begin
      out_valid <= vld[STAGES-2];
      result    <= sat_res;
      overflow  <= sat_ovf;
    end
  end

endmodule

// File: tb/tb_mult_pipe_sat.sv
// Bench for mult_pipe_sat.
// dut0 uses the default parameters. dut1 uses A_W=B_W=12, OUT_W=24, SHIFT=0, STAGES=4.
// The reference model is plain integer arithmetic on longint values.
module tb_mult_pipe_sat;

`ifdef MULT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [15:0] a, b, res;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
  logic [11:0] a2, b2;
  logic [23:0] res2;

  mult_pipe_sat dut0 (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dataa(a), .datab(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(res), .overflow(ovf)
  );

  mult_pipe_sat #(.A_W(12), .B_W(12), .OUT_W(24), .SHIFT(0), .STAGES(4)) dut1 (
    .clock(clk), .reset(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .dataa(a2), .datab(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(res2), .overflow(ovf2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact product, optional half-up rounding, floor shift, clip.
  function automatic void model(input longint av, input longint bv, input int sh, input int ow,
                                output longint r, output bit o);
    longint p, mx, mn;
    p = av * bv;
    if (RND && sh > 0) p = p + (longint'(1) << (sh - 1));
    p  = p >>> sh;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -(longint'(1) << (ow - 1));
    if (p > mx)      begin r = mx; o = 1'b1; end
    else if (p < mn) begin r = mn; o = 1'b1; end
    else             begin r = p;  o = 1'b0; end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on dut0 with out_ready high: checks latency, value and the trailing bubble.
  task automatic one_txn(input longint av, input longint bv, input longint er, input bit eo, input string tag);
    int lat;
    out_ready = 1'b1;
    a = 16'(av);
    b = 16'(bv);
    in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " result"}, $signed(res), er);
    chk({tag, " overflow"}, ovf, eo);
    step();
    chk({tag, " out_valid drop"}, out_valid, 0);
  endtask

  typedef struct {
    longint a;
    longint b;
    longint r;
    bit     o;
  } vec_t;

  vec_t   vecs[8];
  longint q[$];
  bit     qo[$];

  initial begin
    int     cnt, sent, got, cyc, first_acc, first_out;
    bit     prev_stall;
    logic [15:0] prev_r;
    longint er, sa[25], sb[25];
    bit     eo;

    vecs[0] = '{16384, 16384, 8192, 1'b0};
    vecs[1] = '{-32768, -32768, 32767, 1'b1};
    vecs[2] = '{32767, -32768, -32767, 1'b0};
    vecs[3] = '{3, 16384, RND ? 2 : 1, 1'b0};
    vecs[4] = '{-3, 16384, RND ? -1 : -2, 1'b0};
    vecs[5] = '{32767, 32767, 32766, 1'b0};
    vecs[6] = '{-1, 1, RND ? 0 : -1, 1'b0};
    vecs[7] = '{0, -32768, 0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;

    // Reset state and release.
    step(); step(); step();
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", res, 0);
    chk("reset overflow", ovf, 0);
    chk("reset in_ready dut1", in_ready2, 0);
    rst = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid || out_valid2) cnt++;
    end
    chk("no spurious out_valid", cnt, 0);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      one_txn(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, $sformatf("vec%0d", i));
    end

    // Random stream with out_ready toggling 1,0,1,0...
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_r = '0;
    while ((sent < 8 || got < 8) && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      if (sent < 8 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("stall out_valid held", out_valid, 1);
        chk("stall result held", res, prev_r);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("bp unexpected result", 1, 0);
        end else begin
          chk("bp result", $signed(res), q.pop_front());
          chk("bp overflow", ovf, qo.pop_front());
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_r = res;
      if (in_valid && in_ready) begin
        model(longint'($signed(a)), longint'($signed(b)), 15, 16, er, eo);
        q.push_back(er);
        qo.push_back(eo);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp sent", sent, 8);
    chk("bp received", got, 8);
    chk("bp queue empty", q.size(), 0);

    // Reset with three pairs in flight: the output holds one pair and out_ready is low.
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      #1;
      chk("flush accept", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    chk("flush pipeline full", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("flush in_ready in reset", in_ready, 0);
    step();
    chk("flush out_valid cleared", out_valid, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("flush no results", cnt, 0);
    model(-12345, 23456, 15, 16, er, eo);
    one_txn(-12345, 23456, er, eo, "post-reset");

    // Wide sweep on dut1: exact product, 4-cycle latency, back-to-back stream.
    sa[0] = -2048; sb[0] = -2048;
    sa[1] = 2047;  sb[1] = 2047;
    sa[2] = -2048; sb[2] = 2047;
    sa[3] = 0;     sb[3] = 5;
    sa[4] = -1;    sb[4] = -1;
    for (int i = 5; i < 25; i++) begin
      sa[i] = $urandom_range(4095) - 2048;
      sb[i] = $urandom_range(4095) - 2048;
    end
    q.delete();
    sent = 0; got = 0; cyc = 0; first_acc = -1; first_out = -1;
    while ((sent < 25 || got < 25) && cyc < 100) begin
      if (sent < 25) begin
        in_valid2 = 1'b1;
        a2 = 12'(sa[sent]);
        b2 = 12'(sb[sent]);
      end else begin
        in_valid2 = 1'b0;
      end
      #1;
      if (out_valid2) begin
        if (q.size() == 0) begin
          chk("sweep unexpected result", 1, 0);
        end else begin
          chk("sweep result", $signed(res2), q.pop_front());
        end
        chk("sweep overflow", ovf2, 0);
        if (first_out < 0) first_out = cyc;
        got++;
      end
      if (in_valid2 && in_ready2) begin
        q.push_back(sa[sent] * sb[sent]);
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      step();
      cyc++;
    end
    in_valid2 = 1'b0;
    chk("sweep received", got, 25);
    chk("sweep latency", first_out - first_acc, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
